xor_cipher_arbiter: RTL and testbench

//   Shares one xor_cipher core (instantiated inside) between NUM_REQ byte-stream requesters, each with its own key.

---
 rtl/xor_cipher_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/xor_cipher.sv | 25 ++
 rtl/xor_cipher_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_xor_cipher_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xor_cipher_pkg.sv
// Shared types for the xor_cipher arbiter slice: byte/key types and the
// arbiter sequencing states.
package xor_cipher_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [BYTE_W-1:0] key_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first active request strictly
// after ptr (wrapping), returning both a one-hot vector and an index.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  // One extra bit holds ptr+offset before the wrap; it never exceeds 2*NUM_REQ-1.
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/xor_cipher.sv
// Byte XOR cipher core: key register loaded on load_key, data_out = data_in ^ key
// registered every edge. Neither register is reset; the arbiter reloads the key per grant.
module xor_cipher
  import xor_cipher_pkg::*;
(
  input  logic  clk,
  input  logic  load_key,
  input  key_t  key_in,
  input  byte_t data_in,
  output byte_t data_out
);

  key_t  key_reg;
  byte_t data_out_reg;

  always_ff @(posedge clk) begin
    if (load_key) begin
      key_reg <= key_in;
    end
    data_out_reg <= data_in ^ key_reg;
  end

  assign data_out = data_out_reg;

endmodule

// File: rtl/xor_cipher_arbiter.sv
// Shares one xor_cipher core between NUM_REQ byte-stream requesters, round-robin per burst.
// Optional XOR_CIPHER_KEY_CACHE_EN skips the key load when the granted key is already loaded.
module xor_cipher_arbiter
  import xor_cipher_pkg::*;
#(
  parameter  int NUM_REQ   = 2,
  parameter  int BURST_LEN = 4,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [BYTE_W*NUM_REQ-1:0] req_key,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BYTE_W-1:0]         out_data,
  output logic [IDX_W-1:0]          out_id,
  output logic                      out_last
);

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     ptr_reg, ptr_next;
  logic [IDX_W-1:0]     grant_reg, grant_next;
  logic [NUM_REQ-1:0]   grant_oh_reg, grant_oh_next;
  logic [7:0]           count_reg, count_next;
  byte_t                din_reg, din_next;
  logic                 pend_reg, pend_next;
  logic                 stage_reg, stage_next;
  logic                 out_valid_reg, out_valid_next;
  logic [IDX_W-1:0]     id_reg, id_next;
  logic                 last_reg, last_next;

  byte_t                data_arr [NUM_REQ];
  key_t                 key_arr  [NUM_REQ];
  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic                 load_key;
  key_t                 core_key;
  byte_t                core_dout;
  logic                 slot_open;
  logic                 accept;
  logic                 out_fire;
  logic [7:0]           count_inc;
  logic                 cache_hit;

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*BYTE_W +: BYTE_W];
    assign key_arr[gi]  = req_key[gi*BYTE_W +: BYTE_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  xor_cipher u_core (
    .clk      (clk),
    .load_key (load_key),
    .key_in   (core_key),
    .data_in  (din_reg),
    .data_out (core_dout)
  );

`ifdef XOR_CIPHER_KEY_CACHE_EN
  key_t cache_key_reg;
  logic cache_vld_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_key_reg <= '0;
      cache_vld_reg <= 1'b0;
    end else if (load_key) begin
      cache_key_reg <= core_key;
      cache_vld_reg <= 1'b1;
    end
  end

  assign cache_hit = cache_vld_reg && (key_arr[arb_idx] == cache_key_reg);
`else
  assign cache_hit = 1'b0;
`endif

  // A new byte may enter only when the pipeline is empty and the output slot frees this edge.
  assign slot_open = !pend_reg && (!out_valid_reg || out_ready);
  assign accept    = (state_reg == STREAM) && slot_open && req_valid[grant_reg];
  assign out_fire  = out_valid_reg && out_ready;
  assign count_inc = count_reg + 8'd1;
  assign core_key  = key_arr[grant_reg];
  assign req_ready = ((state_reg == STREAM) && slot_open) ? grant_oh_reg : '0;

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    grant_next     = grant_reg;
    grant_oh_next  = grant_oh_reg;
    count_next     = count_reg;
    din_next       = din_reg;
    pend_next      = pend_reg;
    stage_next     = stage_reg;
    out_valid_next = out_valid_reg;
    id_next        = id_reg;
    last_next      = last_reg;
    load_key       = 1'b0;

    if (out_fire) begin
      out_valid_next = 1'b0;
    end
    // Two-edge pipeline: core samples din_reg, then the result is declared valid.
    if (pend_reg && !stage_reg) begin
      stage_next = 1'b1;
    end
    if (pend_reg && stage_reg) begin
      pend_next      = 1'b0;
      stage_next     = 1'b0;
      out_valid_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (arb_any) begin
          grant_next    = arb_idx;
          grant_oh_next = arb_grant;
          count_next    = '0;
          state_next    = cache_hit ? STREAM : LOAD;
        end
      end
      LOAD: begin
        load_key   = 1'b1;
        count_next = '0;
        state_next = STREAM;
      end
      STREAM: begin
        if (accept) begin
          din_next   = data_arr[grant_reg];
          pend_next  = 1'b1;
          id_next    = grant_reg;
          last_next  = req_last[grant_reg];
          count_next = count_inc;
          if (req_last[grant_reg] || (count_inc == 8'(BURST_LEN))) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (slot_open) begin
          state_next = IDLE;
          ptr_next   = grant_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= IDX_W'(NUM_REQ-1);
      grant_reg     <= '0;
      grant_oh_reg  <= '0;
      count_reg     <= '0;
      din_reg       <= '0;
      pend_reg      <= 1'b0;
      stage_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
      id_reg        <= '0;
      last_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      grant_reg     <= grant_next;
      grant_oh_reg  <= grant_oh_next;
      count_reg     <= count_next;
      din_reg       <= din_next;
      pend_reg      <= pend_next;
      stage_reg     <= stage_next;
      out_valid_reg <= out_valid_next;
      id_reg        <= id_next;
      last_reg      <= last_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = core_dout;
  assign out_id    = id_reg;
  assign out_last  = last_reg;

endmodule

// File: tb/tb_xor_cipher_arbiter.sv
// Directed bench for xor_cipher_arbiter (NUM_REQ=2, BURST_LEN=4); honours XOR_CIPHER_KEY_CACHE_EN
// when counting key-load pulses.
module tb_xor_cipher_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [15:0] req_data = '0;
  logic [15:0] req_key = '0;
  logic [1:0]  req_last = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic [0:0]  out_id;
  logic        out_last;

  int total = 0;
  int bad = 0;

  logic [8:0] byte_q [2][$];
  logic [7:0] key_v [2];
  logic [7:0] got_data [$];
  logic       got_id [$];
  logic       got_last [$];
  int         load_cnt;

  xor_cipher_arbiter #(.NUM_REQ(2), .BURST_LEN(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_key   (req_key),
    .req_last  (req_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic present();
    logic [8:0] e;
    for (int i = 0; i < 2; i++) begin
      req_key[i*8 +: 8] = key_v[i];
      if (byte_q[i].size() > 0) begin
        e = byte_q[i][0];
        req_valid[i] = 1'b1;
        req_data[i*8 +: 8] = e[7:0];
        req_last[i] = e[8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic clear_all();
    byte_q[0].delete();
    byte_q[1].delete();
    got_data.delete();
    got_id.delete();
    got_last.delete();
    load_cnt = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    clear_all();
    present();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Feeds queued bytes, collects output handshakes, counts key-load cycles.
  task automatic pump(input int max_cyc, input int n_exp);
    logic [1:0] acc;
    present();
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (dut.load_key) load_cnt++;
      acc = req_valid & req_ready;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_id.push_back(out_id[0]);
        got_last.push_back(out_last);
        $display("  out byte %02h id %0d last %0b", out_data, out_id, out_last);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) if (acc[i]) void'(byte_q[i].pop_front());
      present();
      if (got_data.size() >= n_exp && byte_q[0].size() == 0 && byte_q[1].size() == 0) break;
    end
  endtask

  task automatic wait_ready(input int r, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
      void'(byte_q[r].pop_front());
      present();
    end
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || req_ready !== 2'b00 || out_last !== 1'b0 || out_id !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b ready=%b last=%b id=%b want 0 00 0 0",
               out_valid, req_ready, out_last, out_id);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || req_ready !== 2'b00) begin
      bad++;
      $display("FAIL reset_idle: got valid=%b ready=%b want 0 00", out_valid, req_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    bit ok;
    clear_all();
    key_v[0] = 8'hB3;
    key_v[1] = 8'h00;
    byte_q[0].push_back({1'b1, 8'hCA});
    present();
    wait_ready(0, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL single_accept: got no accept want accept within 40 cycles");
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_lat1: got out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_lat2: got out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h79 || out_id !== 1'b0 || out_last !== 1'b1) begin
      bad++;
      $display("FAIL single_result: got v=%b d=%02h id=%0d last=%b want 1 79 0 1",
               out_valid, out_data, out_id, out_last);
    end
    $display("single: out %02h id %0d last %0b", out_data, out_id, out_last);
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drained: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    key_v[0] = 8'hAC;
    key_v[1] = 8'h00;
    byte_q[0].push_back({1'b1, 8'h41});
    byte_q[0].push_back({1'b1, 8'h42});
    byte_q[1].push_back({1'b1, 8'hFF});
    pump(200, 3);
    total++;
    if (got_data.size() != 3) begin
      bad++;
      $display("FAIL rr_count: got %0d bytes want 3", got_data.size());
    end else begin
      total++;
      if (got_data[0] !== 8'hED || got_id[0] !== 1'b0) begin
        bad++;
        $display("FAIL rr_first: got %02h id %0d want ED id 0", got_data[0], got_id[0]);
      end
      total++;
      if (got_data[1] !== 8'hFF || got_id[1] !== 1'b1) begin
        bad++;
        $display("FAIL rr_second: got %02h id %0d want FF id 1", got_data[1], got_id[1]);
      end
      total++;
      if (got_data[2] !== 8'hEE || got_id[2] !== 1'b0) begin
        bad++;
        $display("FAIL rr_third: got %02h id %0d want EE id 0", got_data[2], got_id[2]);
      end
    end
    total++;
    if (load_cnt != 3) begin
      bad++;
      $display("FAIL rr_loads: got %0d key loads want 3", load_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int errs;
    clear_all();
    key_v[0] = 8'hB3;
    key_v[1] = 8'h55;
    out_ready = 1'b0;
    byte_q[0].push_back({1'b1, 8'hCA});
    present();
    wait_ready(0, ok);
    if (ok) wait_out(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_result: got no out_valid want result within bound");
    end
    byte_q[1].push_back({1'b1, 8'h00});
    present();
    errs = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 8'h79 || req_ready !== 2'b00 || dut.load_key !== 1'b0) begin
        errs++;
        $display("FAIL bp_stall: cycle %0d got v=%b d=%02h ready=%b load=%b want 1 79 00 0",
                 c, out_valid, out_data, req_ready, dut.load_key);
      end
    end
    total++;
    if (errs != 0) bad++;
    @(posedge clk);
    #1 out_ready = 1'b1;
    pump(100, 2);
    total++;
    if (got_data.size() != 2) begin
      bad++;
      $display("FAIL bp_count: got %0d bytes want 2", got_data.size());
    end else begin
      total++;
      if (got_data[0] !== 8'h79 || got_id[0] !== 1'b0 || got_data[1] !== 8'h55 || got_id[1] !== 1'b1) begin
        bad++;
        $display("FAIL bp_order: got %02h/%0d %02h/%0d want 79/0 55/1",
                 got_data[0], got_id[0], got_data[1], got_id[1]);
      end
    end
    total++;
    if (load_cnt != 1) begin
      bad++;
      $display("FAIL bp_loads: got %0d key loads want 1", load_cnt);
    end
  endtask

  task automatic test_burst();
    logic [7:0] exp_d [6];
    int exp_loads;
    clear_all();
    exp_d = '{8'h5B, 8'h58, 8'h59, 8'h5E, 8'h5F, 8'h5C};
`ifdef XOR_CIPHER_KEY_CACHE_EN
    exp_loads = 1;
`else
    exp_loads = 2;
`endif
    key_v[0] = 8'h5A;
    key_v[1] = 8'h11;
    for (int i = 1; i <= 6; i++) byte_q[0].push_back({1'b0, 8'(i)});
    pump(300, 6);
    total++;
    if (got_data.size() != 6) begin
      bad++;
      $display("FAIL burst_count: got %0d bytes want 6", got_data.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (got_data[i] !== exp_d[i] || got_id[i] !== 1'b0 || got_last[i] !== 1'b0) begin
          bad++;
          $display("FAIL burst_byte%0d: got %02h id %0d last %0b want %02h id 0 last 0",
                   i, got_data[i], got_id[i], got_last[i], exp_d[i]);
        end
      end
    end
    total++;
    if (load_cnt != exp_loads) begin
      bad++;
      $display("FAIL burst_loads: got %0d key loads want %0d", load_cnt, exp_loads);
    end
    byte_q[1].push_back({1'b1, 8'h00});
    pump(15, 7);
    @(negedge clk);
    total++;
    if (got_data.size() != 6 || req_ready !== 2'b01) begin
      bad++;
      $display("FAIL burst_hold: got %0d bytes ready=%b want 6 bytes ready=01",
               got_data.size(), req_ready);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    clear_all();
    present();
    key_v[0] = 8'h5A;
    byte_q[0].push_back({1'b0, 8'h77});
    present();
    wait_ready(0, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rmid_accept: got no accept want accept");
    end
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || req_ready !== 2'b00) begin
      bad++;
      $display("FAIL rmid_pend: got valid=%b ready=%b want 0 00", out_valid, req_ready);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL rmid_discard: got out_valid after reset want none");
    end
    key_v[0] = 8'hB3;
    out_ready = 1'b0;
    byte_q[0].push_back({1'b1, 8'h4F});
    present();
    wait_ready(0, ok);
    if (ok) wait_out(ok);
    total++;
    if (!ok || out_data !== 8'hFC || out_id !== 1'b0 || out_last !== 1'b1) begin
      bad++;
      $display("FAIL rmid_result: got ok=%b d=%02h id=%0d last=%b want 1 FC 0 1",
               ok, out_data, out_id, out_last);
    end
    $display("reset_mid: out %02h", out_data);
    #2 reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_async: got out_valid=%b want 0", out_valid);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    int exp_loads;
`ifdef XOR_CIPHER_KEY_CACHE_EN
    exp_loads = 1;
`else
    exp_loads = 2;
`endif
    apply_reset();
    key_v[0] = 8'hB3;
    key_v[1] = 8'h00;
    byte_q[0].push_back({1'b1, 8'h11});
    byte_q[0].push_back({1'b1, 8'h22});
    pump(200, 2);
    total++;
    if (got_data.size() != 2) begin
      bad++;
      $display("FAIL b2b_count: got %0d bytes want 2", got_data.size());
    end else begin
      total++;
      if (got_data[0] !== 8'hA2 || got_data[1] !== 8'h91 || got_last[0] !== 1'b1 || got_last[1] !== 1'b1) begin
        bad++;
        $display("FAIL b2b_data: got %02h %02h want A2 91", got_data[0], got_data[1]);
      end
    end
    total++;
    if (load_cnt != exp_loads) begin
      bad++;
      $display("FAIL b2b_loads: got %0d key loads want %0d", load_cnt, exp_loads);
    end
  endtask

  initial begin
    key_v[0] = 8'h00;
    key_v[1] = 8'h00;
    load_cnt = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_burst();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
